// File: rtl/game_control.sv
// game_control: number-memory game sequencer.
//   A free-running 20-bit LFSR supplies a random number when start is pressed.
//   The player views it, picks a digit position with the switches, then has
//   up to MAX_TRIES guesses at that digit. A success screen is held for
//   HOLD_CYCLES cycles (or until start) before returning to init.
// Ports:
//   clk          sole clock, all registers on its rising edge
//   rst          synchronous active-high reset
//   btn_start    start button (synchronized, debounced, level)
//   btn_confirm  confirm button (synchronized, debounced, level)
//   sw[3:0]      digit address in state 010, guess in state 011
//   state[2:0]   000 init, 001 show, 010 address, 011 match, 100 success
//   data_0..7    registered display digits
module game_control #(
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned MAX_TRIES   = 3,
  parameter logic [19:0] LFSR_SEED   = 20'h5A5A5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_confirm,
  input  logic [3:0] sw,
  output logic [2:0] state,
  output logic [3:0] data_0,
  output logic [3:0] data_1,
  output logic [3:0] data_2,
  output logic [3:0] data_3,
  output logic [3:0] data_4,
  output logic [3:0] data_5,
  output logic [3:0] data_6,
  output logic [3:0] data_7
);

  // One spare bit above what MAX_TRIES needs, so the counter can never wrap.
  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1) + 1;
  localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);

  typedef enum logic [2:0] {
    ST_INIT    = 3'b000,
    ST_SHOW    = 3'b001,
    ST_ADDR    = 3'b010,
    ST_MATCH   = 3'b011,
    ST_SUCCESS = 3'b100
  } state_t;

  state_t              state_q, state_d;
  logic [19:0]         lfsr_q;
  logic [19:0]         num_q, num_d;
  logic [2:0]          addr_q, addr_d;
  logic [TRIES_W-1:0]  tries_q, tries_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                start_prev_q, confirm_prev_q;
  logic [3:0]          data_q [8];
  logic [3:0]          data_d [8];
  logic                start_edge, confirm_edge;
  logic [3:0]          guess_digit;

  assign start_edge   = btn_start & ~start_prev_q;
  assign confirm_edge = btn_confirm & ~confirm_prev_q;

  // Digit at position data_(3+addr) of the stored number.
  always_comb begin
    guess_digit = 4'h0;
    case (addr_q)
      3'd0:    guess_digit = num_q[19:16];
      3'd1:    guess_digit = num_q[15:12];
      3'd2:    guess_digit = num_q[11:8];
      3'd3:    guess_digit = num_q[7:4];
      3'd4:    guess_digit = num_q[3:0];
      default: guess_digit = 4'h0;
    endcase
  end

  // Next-state logic. Display registers are loaded from the next-state
  // values so that state and data outputs change together on the same edge.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    addr_d  = addr_q;
    tries_d = tries_q;
    hold_d  = hold_q;
    for (int unsigned i = 0; i < 8; i++) data_d[i] = '0;

    case (state_q)
      ST_INIT: begin
        if (start_edge) begin
          num_d   = lfsr_q;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (confirm_edge) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (confirm_edge && (sw <= 4'd4)) begin
          addr_d  = sw[2:0];
          tries_d = '0;
          state_d = ST_MATCH;
        end
      end
      ST_MATCH: begin
        if (confirm_edge) begin
          if (tries_q != TRIES_MAX) tries_d = tries_q + TRIES_W'(1);
          if (sw == guess_digit) begin
            hold_d  = '0;
            state_d = ST_SUCCESS;
          end else if (tries_d == TRIES_MAX) begin
            state_d = ST_INIT;
          end
        end
      end
      ST_SUCCESS: begin
        if (start_edge || (hold_q == HOLD_LAST)) state_d = ST_INIT;
        else hold_d = hold_q + HOLD_W'(1);
      end
      default: state_d = ST_INIT;
    endcase

    case (state_d)
      ST_SHOW, ST_MATCH: begin
        data_d[3] = num_d[19:16];
        data_d[4] = num_d[15:12];
        data_d[5] = num_d[11:8];
        data_d[6] = num_d[7:4];
        data_d[7] = num_d[3:0];
      end
      ST_ADDR: data_d[7] = sw;
      ST_SUCCESS: begin
        data_d[1] = 4'(tries_d);
        data_d[2] = 4'hE;
        data_d[3] = num_d[19:16];
        data_d[4] = num_d[15:12];
        data_d[5] = num_d[11:8];
        data_d[6] = num_d[7:4];
        data_d[7] = num_d[3:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_INIT;
      lfsr_q         <= LFSR_SEED;
      num_q          <= '0;
      addr_q         <= '0;
      tries_q        <= '0;
      hold_q         <= '0;
      // Reset high so a button held through reset must be released first.
      start_prev_q   <= 1'b1;
      confirm_prev_q <= 1'b1;
      for (int unsigned i = 0; i < 8; i++) data_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[16]};
      num_q          <= num_d;
      addr_q         <= addr_d;
      tries_q        <= tries_d;
      hold_q         <= hold_d;
      start_prev_q   <= btn_start;
      confirm_prev_q <= btn_confirm;
      for (int unsigned i = 0; i < 8; i++) data_q[i] <= data_d[i];
    end
  end

  assign state  = state_q;
  assign data_0 = data_q[0];
  assign data_1 = data_q[1];
  assign data_2 = data_q[2];
  assign data_3 = data_q[3];
  assign data_4 = data_q[4];
  assign data_5 = data_q[5];
  assign data_6 = data_q[6];
  assign data_7 = data_q[7];

endmodule

// File: tb/tb_game_control.sv
// Self-checking bench for game_control: randomized game rounds compared
// against a behavioural model of the game rules.
module tb_game_control;

  localparam int unsigned HOLD = 8;
  localparam int unsigned MAXT = 3;
  localparam logic [19:0] SEED = 20'h5A5A5;

  localparam int M_INIT = 0, M_SHOW = 1, M_ADDR = 2, M_MATCH = 3, M_SUCC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_confirm = 1'b0;
  logic [3:0] sw = 4'h0;
  logic [2:0] state;
  logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [3:0] dv [8];

  always #5 clk = ~clk;

  game_control #(
    .HOLD_CYCLES(HOLD),
    .MAX_TRIES  (MAXT),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .btn_confirm(btn_confirm),
    .sw         (sw),
    .state      (state),
    .data_0     (d0),
    .data_1     (d1),
    .data_2     (d2),
    .data_3     (d3),
    .data_4     (d4),
    .data_5     (d5),
    .data_6     (d6),
    .data_7     (d7)
  );

  always_comb dv = '{d0, d1, d2, d3, d4, d5, d6, d7};

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  logic [19:0] m_lfsr = '0;
  logic [19:0] m_edge_lfsr = '0;
  logic [19:0] m_num = '0;
  int          m_tries = 0;
  int          m_addr = 0;
  logic [3:0]  m_sw = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock; the model LFSR value present at that edge is kept for start.
  task automatic tick();
    m_edge_lfsr = m_lfsr;
    @(posedge clk);
    if (rst) m_lfsr = SEED;
    else     m_lfsr = {m_lfsr[18:0], m_lfsr[19] ^ m_lfsr[16]};
    #1;
  endtask

  // Guarantees a low cycle first so the press is a fresh rising edge.
  task automatic press(input bit s, input bit c);
    btn_start = 1'b0;
    btn_confirm = 1'b0;
    tick();
    btn_start = s;
    btn_confirm = c;
    tick();
    btn_start = 1'b0;
    btn_confirm = 1'b0;
  endtask

  function automatic logic [3:0] exp_digit(input int mode, input int i);
    logic [3:0] nib;
    nib = 4'((m_num >> (4 * (7 - i))) & 20'hF);
    case (mode)
      M_SHOW, M_MATCH: return (i >= 3) ? nib : 4'h0;
      M_ADDR:          return (i == 7) ? m_sw : 4'h0;
      M_SUCC: begin
        if (i == 1) return 4'(m_tries);
        if (i == 2) return 4'hE;
        return (i >= 3) ? nib : 4'h0;
      end
      default:         return 4'h0;
    endcase
  endfunction

  task automatic check_disp(input string tag, input int mode);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_d%0d", tag, i), 32'(dv[i]), 32'(exp_digit(mode, i)));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected normal end");
    $fatal(1);
  end

  initial begin
    int k, w, early;
    logic [3:0] tgt, g;

    rst = 1'b1;
    tick();
    tick();
    check("reset_state", 32'(state), 32'(M_INIT));
    check_disp("reset", M_INIT);
    rst = 1'b0;

    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(0, 20);
      repeat (k) tick();
      press(1'b1, 1'b0);
      m_num = m_edge_lfsr;
      check($sformatf("r%0d_show_state", r), 32'(state), 32'(M_SHOW));
      check_disp($sformatf("r%0d_show", r), M_SHOW);

      press(1'b0, 1'b1);
      check($sformatf("r%0d_addr_state", r), 32'(state), 32'(M_ADDR));

      m_sw = 4'(5 + $urandom_range(0, 10));
      sw = m_sw;
      tick();
      check_disp($sformatf("r%0d_addr_echo", r), M_ADDR);
      press(1'b0, 1'b1);
      check($sformatf("r%0d_bad_addr_state", r), 32'(state), 32'(M_ADDR));
      check_disp($sformatf("r%0d_bad_addr", r), M_ADDR);

      m_addr = $urandom_range(0, 4);
      m_sw = 4'(m_addr);
      sw = m_sw;
      press(1'b0, 1'b1);
      m_tries = 0;
      check($sformatf("r%0d_match_state", r), 32'(state), 32'(M_MATCH));
      check_disp($sformatf("r%0d_match", r), M_MATCH);

      tgt = 4'((m_num >> (4 * (4 - m_addr))) & 20'hF);
      w = (r < 4) ? r : $urandom_range(0, 3);
      for (int wi = 0; wi < w; wi++) begin
        g = 4'(tgt + 4'($urandom_range(1, 15)));
        sw = g;
        press(1'b0, 1'b1);
        m_tries++;
        if (m_tries == MAXT) begin
          check($sformatf("r%0d_abort_state", r), 32'(state), 32'(M_INIT));
          check_disp($sformatf("r%0d_abort", r), M_INIT);
        end else begin
          check($sformatf("r%0d_wrong%0d_state", r, wi), 32'(state), 32'(M_MATCH));
        end
      end

      if (w < MAXT) begin
        sw = tgt;
        press(1'b0, 1'b1);
        m_tries++;
        check($sformatf("r%0d_succ_state", r), 32'(state), 32'(M_SUCC));
        check_disp($sformatf("r%0d_succ", r), M_SUCC);
        early = (r >= 4) ? int'($urandom_range(0, 1)) : int'(r == 2);
        if (early != 0) begin
          press(1'b1, 1'b0);
          check($sformatf("r%0d_early_exit", r), 32'(state), 32'(M_INIT));
          check_disp($sformatf("r%0d_early", r), M_INIT);
        end else begin
          repeat (HOLD - 1) tick();
          check($sformatf("r%0d_hold_last", r), 32'(state), 32'(M_SUCC));
          tick();
          check($sformatf("r%0d_hold_exit", r), 32'(state), 32'(M_INIT));
          check_disp($sformatf("r%0d_hold", r), M_INIT);
        end
      end
    end

    // Start held through reset release must not act until re-pressed.
    rst = 1'b1;
    btn_start = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("held_start_state", 32'(state), 32'(M_INIT));
    press(1'b1, 1'b0);
    m_num = m_edge_lfsr;
    check("repress_state", 32'(state), 32'(M_SHOW));
    check_disp("repress", M_SHOW);

    // Start edge coinciding with reset.
    tick();
    rst = 1'b1;
    btn_start = 1'b1;
    tick();
    check("rst_override_state", 32'(state), 32'(M_INIT));
    check_disp("rst_override", M_INIT);
    rst = 1'b0;
    tick();
    check("rst_override_after", 32'(state), 32'(M_INIT));
    btn_start = 1'b0;

    // Coincident start+confirm edges.
    press(1'b1, 1'b1);
    m_num = m_edge_lfsr;
    check("both_init_state", 32'(state), 32'(M_SHOW));
    check_disp("both_init", M_SHOW);
    press(1'b1, 1'b1);
    check("both_show_state", 32'(state), 32'(M_ADDR));

    // Reset in the middle of the success hold.
    m_addr = 0;
    m_sw = 4'h0;
    sw = 4'h0;
    press(1'b0, 1'b1);
    check("mh_match_state", 32'(state), 32'(M_MATCH));
    tgt = m_num[19:16];
    sw = tgt;
    press(1'b0, 1'b1);
    m_tries = 1;
    check("mh_succ_state", 32'(state), 32'(M_SUCC));
    check_disp("mh_succ", M_SUCC);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mh_reset_state", 32'(state), 32'(M_INIT));
    check_disp("mh_reset", M_INIT);
    rst = 1'b0;
    tick();
    check("mh_after_state", 32'(state), 32'(M_INIT));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_control.md
GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 Parameter HOLD_CYCLES, default 100_000_000, is the number of clk cycles state 4 is held before returning to init (1 s at 100 MHz).
REQ-002 Parameter MAX_TRIES, default 3, is the number of wrong guesses allowed in state 3 before aborting to init.
REQ-003 Parameter LFSR_SEED, default 20'h5A5A5, is the nonzero LFSR value loaded on reset.
REQ-004 clk  input  1  sole clock; all registers on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 btn_start  input  1  start button, already synchronized and debounced, level.
REQ-007 btn_confirm  input  1  confirm button, already synchronized and debounced, level.
REQ-008 sw  input  4  switch value; used as the address in state 2 and as the guess in state 3.
REQ-009 state  output  3  game state code: 000 init, 001 show, 010 address, 011 match, 100 success.
REQ-010 data_0 .. data_7  output  4 each  digit values for the downstream display stage.

Function
REQ-011 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-012 Each button SHALL be rising-edge detected against a 1-bit previous-value register; an edge is btn=1 with prev=0 at a clk edge.
REQ-013 The state register SHALL update on the same clk edge at which the button edge is detected, so the new state is visible the cycle after.
REQ-014 A 20-bit LFSR SHALL free-run every cycle in all states: shift left, with the new bit[0] = q[19] XOR q[16].
REQ-015 Number register num[19:0] SHALL be displayed as data_3=num[19:16], data_4=num[15:12], data_5=num[11:8], data_6=num[7:4], data_7=num[3:0].
REQ-016 In init, all data outputs SHALL be 0. A start edge SHALL latch the current LFSR value into num and go to state 001.
REQ-017 In state 001, data_0..2 SHALL be 0 and data_3..7 SHALL show num. A confirm edge SHALL go to state 010.
REQ-018 In state 010, data_7 SHALL equal sw, updated every cycle with 1-cycle latency, and data_0..6 SHALL be 0.
REQ-019 On a confirm edge in state 010: if sw<=4, addr<=sw[2:0], tries<=0 and the state goes to 011; if sw>4, the edge SHALL be ignored and the state stays 010.
REQ-020 In state 011, data_0..2 SHALL be 0 and data_3..7 SHALL show num.
REQ-021 On a confirm edge in state 011, sw SHALL be compared with digit data_(3+addr).
- Equal: tries<=tries+1 and go to 100.
- Unequal: tries<=tries+1; if the new tries equals MAX_TRIES, go to init; otherwise stay in 011.
REQ-022 In state 100:
- data_0=0; data_1=tries, the attempt count including the successful one (1..MAX_TRIES); data_2=4'hE; data_3..7 show num.
- The hold counter SHALL start at 0 on entry.
- Return to init when the counter reaches HOLD_CYCLES-1, or on an earlier start edge.
REQ-023 Button edges not named for the current state SHALL be ignored. If start and confirm edges coincide, only the edge meaningful in the current state acts.
REQ-024 tries SHALL be wide enough for MAX_TRIES (3 bits at the default) and SHALL NOT wrap.
REQ-025 Unused state codes 101..111 SHALL go to init on the next cycle, with all data outputs 0.

Reset
REQ-026 While rst=1 at a clk edge, the block SHALL set: state=000, all data=0, num=0, addr=0, tries=0, hold counter=0, LFSR=LFSR_SEED, and both button prev registers=1.
REQ-027 Because prev resets to 1, a button held through reset SHALL NOT produce an edge until it is released and pressed again.
REQ-028 Asserting rst in any state, including mid-hold in state 100, SHALL reach the reset values after that edge; rst SHALL override all button edges in the same cycle.

Verification
REQ-029 Reset, then a start edge k cycles later -> state=001 and num equals the seed advanced k+1 steps, as computed by the bench model; data_0..2=0.
REQ-030 In state 010 with sw=5, confirm -> state stays 010 and data_7=5. Then sw=2 and confirm -> state=011 with addr=2.
REQ-031 num=20'h3C7A1, addr=2 (digit 7): guesses 1, 7 -> state=100, data_1=2, data_2=E. With HOLD_CYCLES=8, state returns to 000 exactly 8 cycles after entry.
REQ-032 MAX_TRIES=3: three wrong guesses -> state=000 on the cycle after the third confirm, with all data=0.
REQ-033 btn_start held high across reset release -> no transition until the button is released and pressed again. A start edge coinciding with rst=1 -> state stays 000.
REQ-034 Start and confirm edges together in init -> state=001. Together in state 001 -> state=010.
